// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the execute-stage ALU sequencer: ALUop encodings,
// sequencer state encodings and default sizing.
package alu_mul_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 6;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_MUL  = 2'b10;
    localparam logic [1:0] ALU_RSUB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: multiplicand, multiplier and accumulator
// registers plus the accumulate adder. Sequencing comes from the top-level
// FSM through the load/step enables.
module mul_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0] i_mplier,
    output logic [WIDTH-1:0] o_acc_next,
    output logic             o_mplier_next_zero
);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;

    // Accumulator value after this step; the top captures it on the final step
    // so the product is available the cycle the sequencer enters DONE.
    always_comb begin
        o_acc_next         = r_acc + (r_mplier[0] ? r_mcand : '0);
        o_mplier_next_zero = (r_mplier[WIDTH-1:1] == '0);
    end

    // Operand/accumulator registers: load clears the accumulator, step shifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_load) begin
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_acc    <= '0;
        end else if (i_step) begin
            r_acc    <= o_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Execute-stage ALU sequencer. Add/sub complete in one cycle; multiply runs
// an iterative shift-add over WIDTH cycles and stalls the pipeline meanwhile.
// Optional feature macro: MUL_EARLY_TERM_EN (finish the multiply as soon as
// the remaining multiplier bits are all zero).
// Handshake: a op is accepted when start is high in IDLE and flush is low;
// done pulses for one cycle when result/flags are valid. While stall is high
// the pipeline holds start and the operands stable.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       ALUop,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zeroflag,
    output logic             evenflag,
    output logic [1:0]       o_dbg_state
);

    localparam logic [CNT_W-1:0] LP_LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_res_load;
    logic [WIDTH-1:0] w_res_val;
    logic [WIDTH-1:0] w_addsub;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_mplier_next_zero;
    logic             w_accept;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_even;
    logic             r_done;

    mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk                (clk),
        .reset              (reset),
        .i_load             (w_load),
        .i_step             (w_step),
        .i_mcand            (in_1),
        .i_mplier           (in_2),
        .o_acc_next         (w_acc_next),
        .o_mplier_next_zero (w_mplier_next_zero)
    );

    // Single-cycle add/sub path and the end-of-multiply condition.
    always_comb begin
        w_accept = (r_state == S_IDLE) && start && !flush;
        case (ALUop)
            ALU_ADD:            w_addsub = in_1 + in_2;
            ALU_SUB, ALU_RSUB:  w_addsub = in_2 - in_1;
            default:            w_addsub = '0;
        endcase
`ifdef MUL_EARLY_TERM_EN
        w_last = (r_cnt == LP_LAST_CNT) || w_mplier_next_zero;
`else
        w_last = (r_cnt == LP_LAST_CNT);
`endif
    end

    // Next-state and datapath control; flush wins over everything else.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_res_load   = 1'b0;
        w_res_val    = w_addsub;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (ALUop == ALU_MUL) begin
                        w_state_next = S_MUL;
                        w_load       = 1'b1;
                    end else begin
                        w_res_load = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_state_next = S_DONE;
                        w_res_load   = 1'b1;
                        w_res_val    = w_acc_next;
                    end
                end
            end
            // Result was delivered on entry; flush or not, return to IDLE.
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Iteration counter: cleared on load, advanced on each multiply step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_cnt <= '0;
        else if (w_load) r_cnt <= '0;
        else if (w_step) r_cnt <= r_cnt + 1'b1;
    end

    // Registered result, flags and one-cycle done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_even   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_res_load;
            if (w_res_load) begin
                r_result <= w_res_val;
                r_zero   <= (w_res_val == '0);
                r_even   <= ~w_res_val[0];
            end
        end
    end

    assign stall       = ~reset & ((r_state == S_MUL) |
                         ((r_state == S_IDLE) & start & (ALUop == ALU_MUL)));
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign result      = r_result;
    assign zeroflag    = r_zero;
    assign evenflag    = r_even;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: table of add/sub/mul vectors with
// expected result, flags and latency, plus hand sequences for reset, flush
// and start-while-busy.
module tb_alu_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  ALUop;
  logic [31:0] in_1;
  logic [31:0] in_2;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zeroflag;
  logic        evenflag;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        e;
  } vec_t;

  vec_t vecs[10];

  alu_mul_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ALUop       (ALUop),
    .in_1        (in_1),
    .in_2        (in_2),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .zeroflag    (zeroflag),
    .evenflag    (evenflag),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    int hb;
    hb = 0;
    if (op != 2'b10) return 1;
`ifdef MUL_EARLY_TERM_EN
    for (int i = 0; i < 32; i++) if (b[i]) hb = i;
    return hb + 2;
`else
    hb = b[0] ? 0 : 0;
    return 33 + hb;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: presents one op, returns cycles to done and stall cycles seen
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int stall_cnt, output logic stall_pre);
    ALUop = op;
    in_1  = a;
    in_2  = b;
    start = 1'b1;
    #1;
    stall_pre = stall;
    step();
    start = 1'b0;
    lat = 1;
    stall_cnt = 0;
    while (!done && lat < 100) begin
      if (stall) stall_cnt++;
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int scnt;
    logic spre;
    logic [31:0] held;
    logic [31:0] expv;
    logic seen;

    vecs[0] = '{2'b00, 32'd5,          32'd7,          32'd12,         1'b0, 1'b1};
    vecs[1] = '{2'b01, 32'd9,          32'd9,          32'd0,          1'b1, 1'b1};
    vecs[2] = '{2'b11, 32'd1,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[3] = '{2'b00, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b1};
    vecs[4] = '{2'b01, 32'd3,          32'd10,         32'd7,          1'b0, 1'b0};
    vecs[5] = '{2'b10, 32'h0001_0003,  32'h0001_0005,  32'h0008_000F,  1'b0, 1'b0};
    vecs[6] = '{2'b10, 32'd6,          32'd3,          32'd18,         1'b0, 1'b1};
    vecs[7] = '{2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0};
    vecs[8] = '{2'b10, 32'd12345,      32'd0,          32'd0,          1'b1, 1'b1};
    vecs[9] = '{2'b10, 32'd7,          32'h8000_0000,  32'h8000_0000,  1'b0, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    ALUop = 2'b00;
    in_1  = '0;
    in_2  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();

    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zeroflag), 32'd0);
    check("rst_even", 32'(evenflag), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);

    // table-driven vectors
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(vecs[i].res);
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, scnt, spre);
      check($sformatf("v%0d_done", i), 32'(done), 32'd1);
      check($sformatf("v%0d_lat", i), lat, exp_lat(vecs[i].op, vecs[i].b));
      check($sformatf("v%0d_stall_pre", i), 32'(spre), (vecs[i].op == 2'b10) ? 32'd1 : 32'd0);
      check($sformatf("v%0d_stall_cnt", i), scnt, exp_lat(vecs[i].op, vecs[i].b) - 1);
      expv = exp_q.pop_front();
      check($sformatf("v%0d_result", i), result, expv);
      check($sformatf("v%0d_zero", i), 32'(zeroflag), 32'(vecs[i].z));
      check($sformatf("v%0d_even", i), 32'(evenflag), 32'(vecs[i].e));
      step();
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_hold", i), result, expv);
    end

    // flush in IDLE suppresses a same-cycle start
    held = result;
    ALUop = 2'b00; in_1 = 32'd5; in_2 = 32'd7; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check("idle_flush_done", 32'(done), 32'd0);
    check("idle_flush_result", result, held);

    // multiply flushed on cycle 5; a start during MUL is ignored
    ALUop = 2'b10; in_1 = 32'd5; in_2 = 32'hFFFF_FFFF; start = 1'b1;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c < 5; c++) begin
      if (c == 3) begin
        ALUop = 2'b00; in_1 = 32'd1; in_2 = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
      step();
    end
    start = 1'b0;
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_state", 32'(o_dbg_state), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 4; c++) begin
      if (done) seen = 1'b1;
      step();
    end
    check("flush_no_done", 32'(seen), 32'd0);
    check("flush_result_held", result, held);

    // reset asserted on cycle 10 of a multiply
    ALUop = 2'b10; in_1 = 32'h0001_0003; in_2 = 32'h8001_0005; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check("mid_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_result", result, 32'd0);
    check("mr_zero", 32'(zeroflag), 32'd0);
    check("mr_even", 32'(evenflag), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_stall", 32'(stall), 32'd0);
    check("mr_state", 32'(o_dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // normal operation after reset
    do_op(2'b10, 32'd6, 32'd3, lat, scnt, spre);
    check("post_done", 32'(done), 32'd1);
    check("post_lat", lat, exp_lat(2'b10, 32'd3));
    check("post_result", result, 32'd18);
    step();
    do_op(2'b00, 32'd5, 32'd7, lat, scnt, spre);
    check("post_add_lat", lat, 1);
    check("post_add_result", result, 32'd12);
    check("post_add_even", 32'(evenflag), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
